// File: rtl/horner_poly_eval.sv
// Polynomial evaluator y = c[N]*x^N + ... + c[0] using Horner's rule.
// One accumulator and one shared multiply/add step per cycle, sequenced by a small FSM.
module horner_poly_eval #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned XW     = 8,
  parameter int unsigned DEGREE = 2
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      start,
  input  logic [XW-1:0]             x,
  input  logic [(DEGREE+1)*WIDTH-1:0] coef,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          result,
  output logic                      overflow
);

  localparam int unsigned PW = WIDTH + XW;
  localparam int unsigned CW = (DEGREE + 1) * WIDTH;

  if (DEGREE < 1 || DEGREE > 15) begin : gen_bad_degree
    $error("horner_poly_eval: DEGREE must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StMul, StAdd} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [XW-1:0]     x_q, x_d;
  logic [CW-1:0]     coef_q, coef_d;
  logic [3:0]        k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [PW-1:0]     prod;
  logic [WIDTH-1:0]  coef_k;
  logic [WIDTH:0]    sum;

  // Product kept at full width so any bits lost to truncation can flag overflow.
  assign prod   = PW'(acc_q) * PW'(x_q);
  assign coef_k = coef_q[k_q*WIDTH +: WIDTH];
  assign sum    = {1'b0, acc_q} + {1'b0, coef_k};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    x_d      = x_q;
    coef_d   = coef_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x;
          coef_d  = coef;
          acc_d   = coef[DEGREE*WIDTH +: WIDTH];
          k_d     = 4'(DEGREE - 1);
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_d = prod[WIDTH-1:0];
        if (|prod[PW-1:WIDTH]) ovf_d = 1'b1;
        state_d = StAdd;
      end
      StAdd: begin
        if (sum[WIDTH]) ovf_d = 1'b1;
        if (k_q != 4'd0) begin
          acc_d   = sum[WIDTH-1:0];
          k_d     = k_q - 4'd1;
          state_d = StMul;
        end else begin
          result_d = sum[WIDTH-1:0];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      result_q <= '0;
      x_q      <= '0;
      coef_q   <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      x_q      <= x_d;
      coef_q   <= coef_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule
